ff_stream_loader: RTL and testbench
===================================

Name: ff_stream_loader

Overview:
- Transmitter side of the feed-forward engine's load stream.
- Buffers host-written payload words: weights, then biases, then first-layer neuron inputs.
- On start, issues the single-cycle `load` pulse, then one word per cycle with no gaps:
  - all weights, then bias marker 0x80000000,
  - all biases, then neuron marker 0xFFFFFFFF,
  - all inputs, then end marker 0xFFFFFFF0.
- Sits between the host/config interface and the engine's `load`/`data` inputs. The engine has no stall, so the whole burst is buffered before transmission.

Parameters:
- DEPTH, 256, payload buffer depth in 32-bit words (max nw+nb+ni).
- ADR_W, 9, width of counts/pointers; must satisfy 2^ADR_W > DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- wr_en  input  1  host payload write strobe.
- wr_data  input  32  payload word (IEEE-754).
- wr_ready  output  1  high when a write will be accepted.
- clear  input  1  empties buffer; accepted only in IDLE.
- n_weights  input  ADR_W  weight count, latched at start.
- n_biases  input  ADR_W  bias count, latched at start.
- n_inputs  input  ADR_W  input count, latched at start.
- start  input  1  begin transmission.
- load  output  1  one-cycle pulse to engine.
- data  output  32  stream word to engine.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after end marker.
- start_err  output  1  one-cycle pulse, start rejected.
- overflow  output  1  sticky: write attempted while full.
- sanitized  output  ADR_W  payload words rewritten this burst.

Behaviour:
- Reset (rst=0, async) values:
  - load=0, data=0, busy=0, done=0, start_err=0, overflow=0, sanitized=0.
  - Fill count=0, state=IDLE.
  - wr_ready=1 after release.
- States: IDLE, PULSE, SEND, FINISH.
- IDLE:
  - wr_ready = (fill<DEPTH).
  - A write with wr_en&wr_ready stores at buffer[fill], then fill+1.
  - A write with wr_en at fill==DEPTH is dropped and sets `overflow` (cleared only by reset or `clear`).
  - `clear` sets fill=0 and overflow=0. `clear` has priority over a same-cycle write and start.
- Start acceptance:
  - `start` in IDLE with fill == n_weights+n_biases+n_inputs (computed ADR_W+2 bits wide, no wrap) latches the counts, resets `sanitized`, goes to PULSE.
  - Any other `start` in IDLE pulses start_err the next cycle and stays in IDLE.
  - `start` outside IDLE is ignored (no error).
- PULSE: load=1 for exactly this cycle, data=0, busy=1, then SEND.
- SEND: one word per cycle, rd pointer from 0, inserting markers at section boundaries.
  - Total words = N+3, where N = fill.
  - If start is sampled at edge T: load is high in cycle T+1, word k is presented in cycle T+2+k, and the end marker is in cycle T+N+4.
  - Empty sections (count 0) still emit their marker; all counts 0 gives exactly 3 marker words.
- Sanitizing: a payload word equal to a marker value must not reach the engine.
  - 0x80000000 is sent as 0x00000000.
  - 0xFFFFFFFF and 0xFFFFFFF0 are sent as 0x7FC00000.
  - Each substitution increments `sanitized`, saturating at all-ones.
- FINISH (cycle after end marker): done=1 and busy=0 in the same cycle, data=0, fill=0, back to IDLE.
- Writes during PULSE/SEND/FINISH: wr_ready=0, ignored, no overflow.
- busy stays 1 from PULSE through the end-marker cycle inclusive.
- Reset mid-burst aborts immediately with all outputs at reset values; the engine is re-armed by a fresh load.

Test Plan:
- Write 2 weights (0x3F800000, 0x40000000), 1 bias 0x3F000000, 2 inputs (0x40400000, 0x40800000); counts 2/1/2; start -> load one cycle, then data = 3F800000, 40000000, 80000000, 3F000000, FFFFFFFF, 40400000, 40800000, FFFFFFF0 on consecutive cycles; done next cycle; busy high for 9 cycles.
- fill=3 with counts 2/1/1; start -> start_err pulse, load stays 0, buffer intact; then set n_inputs=0 and start -> stream of 6 words.
- Payload weights 0x80000000 and 0xFFFFFFFF, counts 2/0/0 -> data 00000000, 7FC00000, 80000000, FFFFFFFF, FFFFFFF0; sanitized=2.
- Counts 0/0/0, empty buffer, start -> load, then 80000000, FFFFFFFF, FFFFFFF0; done.
- DEPTH writes then one more write -> overflow=1, fill=DEPTH; clear -> overflow=0, wr_ready=1.
- Assert rst low during the SEND word 3 -> load/data/busy=0 immediately; after release, fill=0 and a new fill+start streams correctly.

Source files
------------

// File: rtl/ff_stream_loader_if.sv
// ff_stream_loader_if: host/engine-side bus of the feed-forward load-stream transmitter.
// Ports (slave = loader view):
//   host  -> loader : wr_en, wr_data, clear, n_weights, n_biases, n_inputs, start
//   loader -> host  : wr_ready, busy, done, start_err, overflow, sanitized
//   loader -> engine: load, data
interface ff_stream_loader_if #(
    parameter int ADR_W = 9
);
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             wr_ready;
    logic             clear;
    logic [ADR_W-1:0] n_weights;
    logic [ADR_W-1:0] n_biases;
    logic [ADR_W-1:0] n_inputs;
    logic             start;
    logic             load;
    logic [31:0]      data;
    logic             busy;
    logic             done;
    logic             start_err;
    logic             overflow;
    logic [ADR_W-1:0] sanitized;

    modport slave (
        input  wr_en, wr_data, clear, n_weights, n_biases, n_inputs, start,
        output wr_ready, load, data, busy, done, start_err, overflow, sanitized
    );

    modport master (
        output wr_en, wr_data, clear, n_weights, n_biases, n_inputs, start,
        input  wr_ready, load, data, busy, done, start_err, overflow, sanitized
    );
endinterface

// File: rtl/ff_stream_loader.sv
// ff_stream_loader: buffers a whole weight/bias/input payload, then streams it to the engine gap-free.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : ff_stream_loader_if.slave (host write/config side plus engine load/data side)
module ff_stream_loader #(
    parameter int DEPTH = 256,
    parameter int ADR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    ff_stream_loader_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADR_W-1:0] DEPTH_W = ADR_W'(DEPTH);
    localparam logic [31:0] BIAS_MK = 32'h8000_0000;
    localparam logic [31:0] NEUR_MK = 32'hFFFF_FFFF;
    localparam logic [31:0] END_MK  = 32'hFFFF_FFF0;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, PULSE, SEND, FINISH} state_t;

    state_t           state_q;
    logic [31:0]      mem_q [DEPTH];
    logic [ADR_W-1:0] fill_q;
    logic [AW-1:0]    rd_q;
    logic [ADR_W-1:0] left_q;
    logic [ADR_W-1:0] nb_q;
    logic [ADR_W-1:0] ni_q;
    logic [ADR_W-1:0] sanitized_q;
    logic [1:0]       sec_q;
    logic             last_q;
    logic             load_q;
    logic             busy_q;
    logic             done_q;
    logic             start_err_q;
    logic             overflow_q;
    logic [31:0]      data_q;

    logic             idle;
    logic             full;
    logic             wr_acc;
    logic [ADR_W+1:0] total;
    logic [31:0]      word;
    logic [31:0]      clean;
    logic [31:0]      marker;
    logic             hit;

    assign idle   = state_q == IDLE;
    assign full   = fill_q >= DEPTH_W;
    assign wr_acc = idle && !bus.clear && bus.wr_en && !full;
    // Widened sum so large counts cannot wrap into a false match with fill.
    assign total  = {2'b00, bus.n_weights} + {2'b00, bus.n_biases} + {2'b00, bus.n_inputs};
    assign word   = mem_q[rd_q];
    // Payload words that collide with a marker value must never reach the engine.
    assign hit    = word == BIAS_MK || word == NEUR_MK || word == END_MK;
    assign clean  = word == BIAS_MK ? 32'h0 : hit ? QNAN : word;
    assign marker = sec_q == 2'd0 ? BIAS_MK : sec_q == 2'd1 ? NEUR_MK : END_MK;

    assign bus.wr_ready  = idle && !full;
    assign bus.load      = load_q;
    assign bus.data      = data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.start_err = start_err_q;
    assign bus.overflow  = overflow_q;
    assign bus.sanitized = sanitized_q;

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[fill_q[AW-1:0]] <= bus.wr_data;
    end

    // The state names what is on the outputs this cycle; each edge out of
    // PULSE/SEND computes the next word, so the stream runs without gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            rd_q        <= '0;
            left_q      <= '0;
            nb_q        <= '0;
            ni_q        <= '0;
            sanitized_q <= '0;
            sec_q       <= '0;
            last_q      <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            load_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        fill_q     <= '0;
                        overflow_q <= 1'b0;
                    end else begin
                        if (bus.wr_en) begin
                            if (full) overflow_q <= 1'b1;
                            else fill_q <= fill_q + 1'b1;
                        end
                        if (bus.start) begin
                            if (total == {2'b00, fill_q}) begin
                                state_q     <= PULSE;
                                load_q      <= 1'b1;
                                busy_q      <= 1'b1;
                                data_q      <= '0;
                                sanitized_q <= '0;
                                rd_q        <= '0;
                                sec_q       <= '0;
                                last_q      <= 1'b0;
                                left_q      <= bus.n_weights;
                                nb_q        <= bus.n_biases;
                                ni_q        <= bus.n_inputs;
                            end else begin
                                start_err_q <= 1'b1;
                            end
                        end
                    end
                end
                PULSE, SEND: begin
                    if (last_q) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        data_q  <= '0;
                        fill_q  <= '0;
                    end else if (left_q != '0) begin
                        state_q <= SEND;
                        data_q  <= clean;
                        rd_q    <= rd_q + 1'b1;
                        left_q  <= left_q - 1'b1;
                        if (hit && sanitized_q != '1) sanitized_q <= sanitized_q + 1'b1;
                    end else begin
                        // Section exhausted (possibly empty): emit its marker and load the next count.
                        state_q <= SEND;
                        data_q  <= marker;
                        sec_q   <= sec_q + 2'd1;
                        left_q  <= sec_q == 2'd0 ? nb_q : ni_q;
                        last_q  <= sec_q == 2'd2;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_stream_loader.sv
// tb_ff_stream_loader: randomized self-checking bench for ff_stream_loader against a queue-based stream model.
module tb_ff_stream_loader;
    localparam int DEPTH = 256;
    localparam int ADR_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ff_stream_loader_if #(.ADR_W(ADR_W)) bus ();

    ff_stream_loader #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] payload [$];
    bit exp_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] clean(input logic [31:0] w);
        if (w == 32'h8000_0000) return 32'h0;
        if (w == 32'hFFFF_FFFF || w == 32'hFFFF_FFF0) return 32'h7FC0_0000;
        return w;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'hFFFF_FFF0;
            default: return $urandom;
        endcase
    endfunction

    task automatic write_word(input logic [31:0] w);
        bus.wr_en = 1'b1;
        bus.wr_data = w;
        step();
        bus.wr_en = 1'b0;
        if (payload.size() < DEPTH) payload.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        payload.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic set_counts(input int nw, input int nb, input int ni);
        bus.n_weights = ADR_W'(nw);
        bus.n_biases = ADR_W'(nb);
        bus.n_inputs = ADR_W'(ni);
    endtask

    // Model: the stream is each section's cleaned payload followed by that section's marker.
    task automatic run_burst(input string name, input int nw, input int nb, input int ni);
        logic [31:0] exp [$];
        logic [31:0] mk [3];
        int cnt [3];
        int p = 0;
        int sani = 0;
        mk[0] = 32'h8000_0000; mk[1] = 32'hFFFF_FFFF; mk[2] = 32'hFFFF_FFF0;
        cnt[0] = nw; cnt[1] = nb; cnt[2] = ni;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < cnt[s]; i++) begin
                exp.push_back(clean(payload[p]));
                if (clean(payload[p]) != payload[p]) sani++;
                p++;
            end
            exp.push_back(mk[s]);
        end
        if (sani > (1 << ADR_W) - 1) sani = (1 << ADR_W) - 1;
        set_counts(nw, nb, ni);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, ".load"}, 32'(bus.load), 32'd1);
        check({name, ".pulse_busy"}, 32'(bus.busy), 32'd1);
        check({name, ".pulse_data"}, bus.data, 32'h0);
        foreach (exp[k]) begin
            step();
            check($sformatf("%s.word%0d", name, k), bus.data, exp[k]);
            check($sformatf("%s.busy%0d", name, k), {30'h0, bus.busy, bus.load}, 32'd2);
        end
        step();
        check({name, ".done"}, {29'h0, bus.done, bus.busy, bus.wr_ready}, 32'd4);
        check({name, ".finish_data"}, bus.data, 32'h0);
        check({name, ".sanitized"}, 32'(bus.sanitized), 32'(sani));
        step();
        payload.delete();
        check({name, ".idle"}, {30'h0, bus.done, bus.wr_ready}, 32'd1);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.clear = 1'b0;
        bus.start = 1'b0;
        set_counts(0, 0, 0);
        repeat (2) step();
        check("reset.outs", {26'h0, bus.load, bus.busy, bus.done, bus.start_err, bus.overflow, 1'b0}, 32'h0);
        check("reset.data", bus.data, 32'h0);
        check("reset.sanitized", 32'(bus.sanitized), 32'h0);
        rst = 1'b1;
        step();
        check("reset.wr_ready", 32'(bus.wr_ready), 32'd1);

        write_word(32'h3F80_0000);
        write_word(32'h4000_0000);
        write_word(32'h3F00_0000);
        write_word(32'h4040_0000);
        write_word(32'h4080_0000);
        run_burst("basic", 2, 1, 2);

        write_word(32'h3F80_0000);
        write_word(32'h4000_0000);
        write_word(32'h3F00_0000);
        set_counts(2, 1, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("err.start_err", 32'(bus.start_err), 32'd1);
        check("err.load", {30'h0, bus.load, bus.busy}, 32'd0);
        step();
        check("err.pulse_len", 32'(bus.start_err), 32'd0);
        run_burst("err_retry", 2, 1, 0);

        write_word(32'h8000_0000);
        write_word(32'hFFFF_FFFF);
        run_burst("sanitize", 2, 0, 0);

        run_burst("empty", 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int nw = $urandom_range(0, 8);
            int nb = $urandom_range(0, 4);
            int ni = $urandom_range(0, 8);
            for (int i = 0; i < nw + nb + ni; i++) write_word(rand_word());
            run_burst($sformatf("rand%0d", r), nw, nb, ni);
        end

        for (int i = 0; i < DEPTH; i++) write_word(rand_word());
        check("full.wr_ready", 32'(bus.wr_ready), 32'd0);
        check("full.overflow", 32'(bus.overflow), 32'd0);
        write_word(32'h1234_5678);
        check("ovf.overflow", 32'(bus.overflow), 32'(exp_ovf));
        set_counts(DEPTH - 1, 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ovf.fill_not_255", 32'(bus.start_err), 32'd1);
        run_burst("full_burst", 100, 100, DEPTH - 200);
        check("ovf.sticky", 32'(bus.overflow), 32'd1);
        do_clear();
        check("clear.overflow", {30'h0, bus.overflow, bus.wr_ready}, 32'd1);

        for (int i = 0; i < 5; i++) write_word($urandom);
        set_counts(5, 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("abort.word3", bus.data, clean(payload[3]));
        #2 rst = 1'b0;
        #1;
        check("abort.outs", {29'h0, bus.load, bus.busy, bus.done}, 32'h0);
        check("abort.data", bus.data, 32'h0);
        step();
        rst = 1'b1;
        payload.delete();
        step();
        check("abort.wr_ready", 32'(bus.wr_ready), 32'd1);
        run_burst("after_abort_empty", 0, 0, 0);
        for (int i = 0; i < 3; i++) write_word(rand_word());
        run_burst("after_abort", 1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
